inbuf_tile_loader: RTL
======================

# inbuf_tile_loader

Producer stage for the input-buffer ping-pong controller. Accepts a stream of 4-bit activations, packs them into buffer words, and writes one tile per grant into the bank selected by `ping_pong_write`. Signals tile completion with a one-cycle `write_finish` pulse and flags the final tile of a layer with `last_tile`. Sits between the activation fetch stream and the ping-pong input buffers.

## Interface
- `DATA_W`, 4, activation width in bits
- `PACK`, 8, activations per buffer word (word width `DATA_W*PACK`)
- `TILE_WORDS`, 64, buffer words per tile
- `NUM_TILES`, 16, tiles per layer
- `ADDR_W`, clog2(TILE_WORDS), buffer word address width
- `TILE_W`, clog2(NUM_TILES) (min 1), tile index width

Ports:
- `clki` in 1: clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that begins a layer load.
- `s_valid` in 1: upstream activation valid.
- `s_data` in `DATA_W`: upstream activation.
- `s_ready` out 1: loader accepts `s_data`.
- `buf_wr_rdy` in 1: level from the ping-pong controller. High means the bank indexed by `ping_pong_write` may be written.
- `ping_pong_write` in 1: write bank select. 0 = bank A, 1 = bank B.
- `wr_en_a`, `wr_en_b` out 1: write strobes, one per bank.
- `wr_addr` out `ADDR_W`: word address within the tile.
- `wr_data` out `DATA_W*PACK`: packed word.
- `write_finish` out 1: one-cycle pulse, tile fully written.
- `last_tile` out 1: level, current or just-finished tile is the last in the layer.
- `busy` out 1: layer load in progress.
- `tile_idx` out `TILE_W`: index of the tile being loaded.

## Operation
- FSM states: IDLE, WAIT_BANK, FILL, FLUSH, FINISH.
- IDLE:
  - `start` clears `tile_idx` and `last_tile`, then goes to WAIT_BANK.
  - `start` in any other state is ignored.
- WAIT_BANK:
  - `last_tile` is set if `tile_idx == NUM_TILES-1`.
  - On `buf_wr_rdy=1`, latch `ping_pong_write` as the target bank, clear the word and pack counters, and go to FILL.
- FILL:
  - `s_ready=1`. Each handshake (`s_valid & s_ready`) places `s_data` into pack slot `pack_cnt`, LSB-first: slot k occupies bits [k*DATA_W +: DATA_W].
  - When the slot `PACK-1` handshake occurs, the word is written on the next cycle: strobe for the latched bank, `wr_addr=word_cnt`, then `word_cnt` increments.
  - The final nibble of word `TILE_WORDS-1` moves the FSM to FLUSH.
- FLUSH: `s_ready=0`. The final word's write strobe is active this cycle.
- FINISH:
  - `write_finish=1` for one cycle.
  - If `tile_idx == NUM_TILES-1`, go to IDLE. `last_tile` stays high until the next `start`.
  - Otherwise increment `tile_idx` and go to WAIT_BANK.
- Bank latched per tile:
  - `ping_pong_write` changes after the grant are ignored.
  - `buf_wr_rdy` deasserting during FILL is ignored.
- `busy` = state ≠ IDLE.
- Only the latched bank's strobe may be high. `wr_en_a & wr_en_b` is never 1.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, partial pack discarded.
- `rst_n` low mid-tile aborts immediately. No `write_finish` is issued for the aborted tile.
- `s_ready` derives only from registered state (no combinational path from `s_valid`). Throughput is one nibble per cycle.
- Write latency: nibble that completes a word accepted at cycle t → strobe, `wr_addr`, `wr_data` valid at t+1.
- Last nibble of a tile accepted at t:
  - final write at t+1 (FLUSH)
  - `write_finish` at t+2
  - WAIT_BANK or IDLE at t+3
- `write_finish` is never coincident with a write strobe.
- `last_tile` is valid no later than the cycle the last tile is granted. It is stable while that tile's `write_finish` is high.
- Minimum tile time: `TILE_WORDS*PACK + 3` cycles from grant to next WAIT_BANK.
- `NUM_TILES=1`: `last_tile` rises on the first WAIT_BANK cycle.
- Counter wrap: `word_cnt` and `pack_cnt` reset per tile. `tile_idx` never wraps past `NUM_TILES-1`.

## Structure
- Package `inbuf_pkg`:
  - FSM state enum
  - default values of `DATA_W`, `PACK`, `TILE_WORDS`, `NUM_TILES`
  - bank encoding constants (A=0, B=1)
- Sub-module `nibble_packer`:
  - holds the shift/slot register and `pack_cnt`
  - outputs the packed word and a `word_done` strobe
  - cleared per tile

## Test plan
Bench parameters: `PACK=8`, `TILE_WORDS=4`, `NUM_TILES=3`.
1. Reset mid-FILL after 13 nibbles → all outputs 0 next cycle. A following `start` loads from `wr_addr=0` with no `write_finish` for the aborted tile.
2. `start`, `buf_wr_rdy=1`, `ping_pong_write=0`, nibbles 0x0..0xF continuous → `wr_en_a` at addr 0 with data 0x76543210, addr 1 with 0xFEDCBA98. `wr_en_b` never high.
3. Full tile, continuous valid → `write_finish` exactly 2 cycles after the 32nd handshake. One pulse only.
4. `s_valid` toggled 1-0-1 every cycle → correct words. `write_finish` delayed only by the stall count.
5. Three tiles with `ping_pong_write` = 0, 1, 0 at grant, and `ping_pong_write` flipped mid-FILL of tile 1 → writes go to A, B, A respectively. `last_tile=1` from tile 2's grant through IDLE. `busy=0` after the 3rd `write_finish`.
6. `buf_wr_rdy=0` for 20 cycles in WAIT_BANK, with `start` pulsed during FILL → `s_ready` held 0 while waiting. The extra `start` has no effect and `tile_idx` is unchanged.

Source files
------------

// File: rtl/inbuf_tile_loader_pkg.sv
// Shared types and defaults for the input-buffer tile loader.
// Holds the FSM state encoding, parameter defaults and bank encoding.
package inbuf_pkg;

  localparam int DATA_W_DEF     = 4;
  localparam int PACK_DEF       = 8;
  localparam int TILE_WORDS_DEF = 64;
  localparam int NUM_TILES_DEF  = 16;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BANK,
    ST_FILL,
    ST_FLUSH,
    ST_FINISH
  } state_e;

  // Counter widths never collapse to zero bits, even for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inbuf_tile_loader_if.sv
// Activation stream, bank handshake and buffer write bus of the tile loader.
// The master modport is the loader itself; slave is the surrounding fabric.
interface inbuf_tile_loader_if
  import inbuf_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PACK       = PACK_DEF,
  parameter int TILE_WORDS = TILE_WORDS_DEF,
  parameter int NUM_TILES  = NUM_TILES_DEF
) ();

  localparam int ADDR_W = clog2_min1(TILE_WORDS);
  localparam int TILE_W = clog2_min1(NUM_TILES);

  logic                     start;
  logic                     s_valid;
  logic [DATA_W-1:0]        s_data;
  logic                     s_ready;
  logic                     buf_wr_rdy;
  logic                     ping_pong_write;
  logic                     wr_en_a;
  logic                     wr_en_b;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W*PACK-1:0]   wr_data;
  logic                     write_finish;
  logic                     last_tile;
  logic                     busy;
  logic [TILE_W-1:0]        tile_idx;

  modport master (
    input  start, s_valid, s_data, buf_wr_rdy, ping_pong_write,
    output s_ready, wr_en_a, wr_en_b, wr_addr, wr_data,
           write_finish, last_tile, busy, tile_idx
  );

  modport slave (
    output start, s_valid, s_data, buf_wr_rdy, ping_pong_write,
    input  s_ready, wr_en_a, wr_en_b, wr_addr, wr_data,
           write_finish, last_tile, busy, tile_idx
  );

endinterface

// File: rtl/inbuf_tile_loader_packer.sv
// Packs accepted activations LSB-first into one buffer word.
// word_done_o pulses the cycle after the final slot lands, with word_o complete.
module nibble_packer
  import inbuf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PACK   = PACK_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic [DATA_W*PACK-1:0] word_o,
  output logic                   word_done_o,
  output logic                   slot_last_o
);

  localparam int CNT_W = clog2_min1(PACK);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PACK - 1);

  logic [CNT_W-1:0]       pack_cnt_q, pack_cnt_d;
  logic [DATA_W*PACK-1:0] slots_q, slots_d;
  logic                   done_q, done_d;

  always_comb begin
    pack_cnt_d = pack_cnt_q;
    slots_d    = slots_q;
    done_d     = 1'b0;
    if (clear_i) begin
      pack_cnt_d = '0;
      slots_d    = '0;
    end else if (valid_i) begin
      slots_d[int'(pack_cnt_q)*DATA_W +: DATA_W] = data_i;
      if (pack_cnt_q == LAST_SLOT) begin
        pack_cnt_d = '0;
        done_d     = 1'b1;
      end else begin
        pack_cnt_d = pack_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pack_cnt_q <= '0;
      slots_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      pack_cnt_q <= pack_cnt_d;
      slots_q    <= slots_d;
      done_q     <= done_d;
    end
  end

  assign word_o      = slots_q;
  assign word_done_o = done_q;
  assign slot_last_o = (pack_cnt_q == LAST_SLOT);

endmodule

// File: rtl/inbuf_tile_loader.sv
// Producer stage for the ping-pong input buffers: packs activations and writes
// one tile per bank grant, pulsing write_finish after each tile's last word.
module inbuf_tile_loader
  import inbuf_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PACK       = PACK_DEF,
  parameter int TILE_WORDS = TILE_WORDS_DEF,
  parameter int NUM_TILES  = NUM_TILES_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  inbuf_tile_loader_if.master bus
);

  localparam int ADDR_W = clog2_min1(TILE_WORDS);
  localparam int TILE_W = clog2_min1(NUM_TILES);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(TILE_WORDS - 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  state_e            state_q, state_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic              last_tile_q, last_tile_d;

  logic                   handshake;
  logic                   grant;
  logic                   slot_last;
  logic                   word_end;
  logic                   tile_end;
  logic                   word_done;
  logic [DATA_W*PACK-1:0] packed_word;

  assign handshake = bus.s_valid & (state_q == ST_FILL);
  assign grant     = (state_q == ST_WAIT_BANK) & bus.buf_wr_rdy;
  assign word_end  = handshake & slot_last;
  assign tile_end  = word_end & (word_cnt_q == LAST_WORD);

  nibble_packer #(
    .DATA_W (DATA_W),
    .PACK   (PACK)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (grant),
    .valid_i     (handshake),
    .data_i      (bus.s_data),
    .word_o      (packed_word),
    .word_done_o (word_done),
    .slot_last_o (slot_last)
  );

  // last_tile is raised on entry to WAIT_BANK so it is valid before the grant.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    word_cnt_d  = word_cnt_q;
    wr_addr_d   = wr_addr_q;
    tile_idx_d  = tile_idx_q;
    last_tile_d = last_tile_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          tile_idx_d  = '0;
          last_tile_d = (NUM_TILES == 1);
          state_d     = ST_WAIT_BANK;
        end
      end
      ST_WAIT_BANK: begin
        if (tile_idx_q == LAST_TILE) last_tile_d = 1'b1;
        if (bus.buf_wr_rdy) begin
          bank_d     = bus.ping_pong_write;
          word_cnt_d = '0;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (word_end) begin
          wr_addr_d  = word_cnt_q;
          word_cnt_d = word_cnt_q + ADDR_W'(1);
          if (tile_end) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (tile_idx_q == LAST_TILE) begin
          state_d = ST_IDLE;
        end else begin
          tile_idx_d  = tile_idx_q + TILE_W'(1);
          last_tile_d = ((tile_idx_q + TILE_W'(1)) == LAST_TILE);
          state_d     = ST_WAIT_BANK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      bank_q      <= BANK_A;
      word_cnt_q  <= '0;
      wr_addr_q   <= '0;
      tile_idx_q  <= '0;
      last_tile_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      word_cnt_q  <= word_cnt_d;
      wr_addr_q   <= wr_addr_d;
      tile_idx_q  <= tile_idx_d;
      last_tile_q <= last_tile_d;
    end
  end

  assign bus.s_ready      = (state_q == ST_FILL);
  assign bus.wr_en_a      = word_done & (bank_q == BANK_A);
  assign bus.wr_en_b      = word_done & (bank_q == BANK_B);
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = packed_word;
  assign bus.write_finish = (state_q == ST_FINISH);
  assign bus.last_tile    = last_tile_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.tile_idx     = tile_idx_q;

endmodule
